twiddle_mult: RTL and testbench
===============================

TWIDDLE_MULT -- requirements
Module: twiddle_mult

Interface
REQ-001 SHALL have parameter LOG_N, default 6, meaning log2 of FFT stage size; the legal values are 6 (64-point) and 4 (16-point).
REQ-002 SHALL have parameter WIDTH, default 16, meaning data width in two's-complement Q1.15 format.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port di_en, input, 1 bit: input sample valid.
REQ-006 SHALL have port di_re, input, WIDTH bits: input sample, real part.
REQ-007 SHALL have port di_im, input, WIDTH bits: input sample, imaginary part.
REQ-008 SHALL have port do_en, output, 1 bit: output sample valid.
REQ-009 SHALL have port do_re, output, WIDTH bits: output sample, real part.
REQ-010 SHALL have port do_im, output, WIDTH bits: output sample, imaginary part.

Function
REQ-011 SHALL keep a 6-bit sample counter `cnt` that increments by 1 on each clock with di_en=1, holds when di_en=0, and wraps 63->0.
REQ-012 SHALL form the twiddle address as tw_addr = cnt[LOG_N-3:0] * {cnt[LOG_N-2], cnt[LOG_N-1]}, shifted left by (6-LOG_N) bits; the maximum address is 45.
REQ-013 SHALL read twiddles from the registered table (1-cycle latency) and delay di_re/di_im/di_en by 1 cycle in matching registers so each sample aligns with its twiddle.
REQ-014 SHALL compute re = a*c - b*d and im = a*d + b*c at full precision (2*WIDTH+1 bits), where a/b are data re/im and c/d are twiddle re/im.
REQ-015 SHALL round each result by adding 2^(WIDTH-2), then shifting arithmetically right by WIDTH-1, then saturating to [0x8000, 0x7FFF].
REQ-016 SHALL bypass the multiplication when the delayed tw_addr equals 0, passing the delayed data unchanged, because the table holds 0 at address 0.
REQ-017 SHALL register the products (stage 2) and then the rounded/saturated or bypassed result (stage 3).
REQ-018 SHALL have a fixed latency: a sample accepted at edge k appears on do_* at edge k+3, with do_en=1 for that cycle only.
REQ-019 SHALL advance the pipeline every clock with no stall or back-pressure; valid gaps in di_en propagate unchanged as do_en gaps.
REQ-020 SHALL clear do_en for any cycle without a corresponding valid input, and SHALL hold do_re/do_im at their last value while do_en=0.
REQ-021 SHALL, on simultaneous wrap (cnt=63) and di_en=1, output sample 63 normally and give the next valid sample cnt=0.

Reset
REQ-022 SHALL, while reset_n=0, force cnt=0, all valid pipeline bits=0, do_en=0, do_re=0 and do_im=0 asynchronously.
REQ-023 SHALL, on reset mid-frame, discard all in-flight samples (no do_en afterward) and assign cnt=0 to the first sample after reset release.

Structure
REQ-024 SHALL take WIDTH defaults, the rounding constant and the saturation limits from the shared FFT package.
REQ-025 SHALL instantiate the existing Twiddle table module once with TW_FF=1; no other sub-modules are used.

Verification
REQ-026 SHALL cover the bypass case: 64 consecutive samples of (0x1234, 0x0567) with LOG_N=6 -> samples cnt 0..15 return exactly (0x1234, 0x0567), 3 cycles later.
REQ-027 SHALL cover the multiply case: (0x4000, 0x0000) at cnt=17 (tw_addr 2, tw=(0x7D8A, 0xE707)) -> do_re=0x3EC5, do_im=0xF384.
REQ-028 SHALL cover saturation: (0x8000, 0x0000) at cnt=24 (tw_addr 16, tw=(0x0000, 0x8000)) -> do_re=0x0000, do_im=0x7FFF.
REQ-029 SHALL cover gaps: di_en toggling 1,0,1,0 over 128 valid samples -> cnt advances only on valid inputs, do_en mirrors the di_en pattern 3 cycles later, and the results match a golden model.
REQ-030 SHALL cover mid-frame reset: assert reset_n=0 at cnt=30 for 2 cycles -> outputs go to 0 at once, no stale do_en appears, and the next sample uses tw_addr 0.
REQ-031 SHALL cover LOG_N=4: 16 samples -> tw_addr sequence {0,0,0,0, 0,8,16,24, 0,4,8,12, 0,12,24,36}.

Source files
------------

// File: rtl/twiddle_mult_pkg.sv
// Shared FFT definitions: data width defaults, rounding/saturation helpers, twiddle ROM.
// Latency: none (pure constants and combinational functions).
// Backpressure: not applicable.
package twiddle_mult_pkg;

    localparam int FFT_WIDTH = 16;   // Q1.15 data path
    localparam int FFT_LOG_N = 6;    // 64-point stage
    localparam int TW_W      = 16;   // twiddle table is stored as Q1.15
    localparam int TW_AW     = 6;    // table covers W64^0 .. W64^63

    typedef struct packed {
        logic [TW_W-1:0] re;
        logic [TW_W-1:0] im;
    } tw_t;

    // Half-LSB rounding bias applied before the Q1.15 renormalising shift.
    function automatic longint rnd_const(input int w);
        return longint'(1) << (w - 2);
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    // round(sin(i*pi/32) * 2^15) for i = 0..16; entry 16 is the unsaturated +1.0
    // so that its negation lands exactly on 0x8000.
    function automatic logic signed [TW_W:0] quarter_sin(input logic [4:0] i);
        logic signed [TW_W:0] v;
        case (i)
            5'd0:    v = 17'sd0;
            5'd1:    v = 17'sd3212;
            5'd2:    v = 17'sd6393;
            5'd3:    v = 17'sd9512;
            5'd4:    v = 17'sd12540;
            5'd5:    v = 17'sd15447;
            5'd6:    v = 17'sd18205;
            5'd7:    v = 17'sd20788;
            5'd8:    v = 17'sd23170;
            5'd9:    v = 17'sd25330;
            5'd10:   v = 17'sd27246;
            5'd11:   v = 17'sd28899;
            5'd12:   v = 17'sd30274;
            5'd13:   v = 17'sd31357;
            5'd14:   v = 17'sd32138;
            5'd15:   v = 17'sd32610;
            5'd16:   v = 17'sd32768;
            default: v = 17'sd0;
        endcase
        return v;
    endfunction

    function automatic logic [TW_W-1:0] sat_tw(input logic signed [TW_W:0] v);
        logic [TW_W-1:0] r;
        if (v > 17'sd32767) r = 16'h7FFF;
        else                r = v[TW_W-1:0];
        return r;
    endfunction

    // W64^k = cos(2*pi*k/64) - j*sin(2*pi*k/64), built from one quarter wave.
    // Address 0 holds 0 because +1.0 is not representable; the multiplier
    // bypasses that address instead.
    function automatic tw_t tw_rom(input logic [TW_AW-1:0] k);
        tw_t                  t;
        logic [4:0]           up;
        logic [4:0]           dn;
        logic signed [TW_W:0] s_up;
        logic signed [TW_W:0] s_dn;
        up   = {1'b0, k[3:0]};
        dn   = 5'd16 - up;
        s_up = quarter_sin(up);
        s_dn = quarter_sin(dn);
        case (k[5:4])
            2'd0:    begin t.re = sat_tw(s_dn);  t.im = sat_tw(-s_up); end
            2'd1:    begin t.re = sat_tw(-s_up); t.im = sat_tw(-s_dn); end
            2'd2:    begin t.re = sat_tw(-s_dn); t.im = sat_tw(s_up);  end
            default: begin t.re = sat_tw(s_up);  t.im = sat_tw(s_dn);  end
        endcase
        if (k == '0) t = '0;
        return t;
    endfunction

endpackage

// File: rtl/twiddle_mult_tw.sv
// Twiddle table: W64^addr in Q1.15, scaled to WIDTH (WIDTH >= 16).
// Latency: 1 cycle when TW_FF=1, combinational when TW_FF=0.
// Backpressure: none; a new address is looked up every cycle.
// Ports: clock; addr (6-bit table index); tw_re/tw_im (twiddle real/imag).
module twiddle_mult_tw
    import twiddle_mult_pkg::*;
#(
    parameter int TW_FF = 1,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clock,
    input  logic [TW_AW-1:0] addr,
    output logic [WIDTH-1:0] tw_re,
    output logic [WIDTH-1:0] tw_im
);

    localparam int SH = WIDTH - TW_W;

    tw_t              rom;
    logic [WIDTH-1:0] re_w;
    logic [WIDTH-1:0] im_w;

    assign rom  = tw_rom(addr);
    assign re_w = WIDTH'($signed(rom.re)) <<< SH;
    assign im_w = WIDTH'($signed(rom.im)) <<< SH;

    if (TW_FF != 0) begin : g_ff
        always_ff @(posedge clock) begin
            tw_re <= re_w;
            tw_im <= im_w;
        end
    end else begin : g_comb
        assign tw_re = re_w;
        assign tw_im = im_w;
    end

endmodule

// File: rtl/twiddle_mult.sv
// FFT stage twiddle multiplier: do = di * W64^tw_addr with Q1.15 rounding and saturation.
// Latency: 3 clocks (table/align register, product register, result register).
// Backpressure: none; pipeline advances every clock, di_en gaps pass through as do_en gaps.
// Ports: clock, reset_n (async, active low); di_en/di_re/di_im in; do_en/do_re/do_im out.
module twiddle_mult
    import twiddle_mult_pkg::*;
#(
    parameter int LOG_N = FFT_LOG_N,
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int PW  = 2 * WIDTH + 1;   // full-precision a*c - b*d
    localparam int PW1 = PW + 1;          // headroom for the rounding add
    localparam int IW  = LOG_N - 2;

    localparam logic signed [PW1-1:0] RND    = PW1'(rnd_const(WIDTH));
    localparam logic signed [PW1-1:0] SAT_HI = PW1'(sat_max(WIDTH));
    localparam logic signed [PW1-1:0] SAT_LO = PW1'(sat_min(WIDTH));

    // ---------------- stage 0: sample counter and twiddle address
    logic [5:0]       cnt;
    logic [IW-1:0]    idx;
    logic [1:0]       rev;
    logic [TW_AW-1:0] tw_addr;

    // The two stage-select bits are swapped (bit-reversed) before forming the
    // exponent; smaller stages are stretched onto the 64-entry table.
    assign idx     = cnt[LOG_N-3:0];
    assign rev     = {cnt[LOG_N-2], cnt[LOG_N-1]};
    assign tw_addr = TW_AW'((TW_AW'(idx) * TW_AW'(rev)) << (6 - LOG_N));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   cnt <= '0;
        else if (di_en) cnt <= cnt + 6'd1;
    end

    // ---------------- stage 1: twiddle lookup and matching data delay
    logic [WIDTH-1:0] tw_re;
    logic [WIDTH-1:0] tw_im;
    logic             en1;
    logic             zero1;
    logic [WIDTH-1:0] re1;
    logic [WIDTH-1:0] im1;

    twiddle_mult_tw #(
        .TW_FF (1),
        .WIDTH (WIDTH)
    ) u_tw (
        .clock (clock),
        .addr  (tw_addr),
        .tw_re (tw_re),
        .tw_im (tw_im)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en1   <= 1'b0;
            zero1 <= 1'b0;
            re1   <= '0;
            im1   <= '0;
        end else begin
            en1   <= di_en;
            zero1 <= (tw_addr == '0);
            re1   <= di_re;
            im1   <= di_im;
        end
    end

    // ---------------- stage 2: full-precision complex products
    logic signed [PW-1:0] ax, bx, cx, dx;
    logic signed [PW-1:0] mul_re, mul_im;
    logic signed [PW-1:0] p_re, p_im;
    logic                 en2;
    logic                 zero2;
    logic [WIDTH-1:0]     re2;
    logic [WIDTH-1:0]     im2;

    assign ax     = PW'($signed(re1));
    assign bx     = PW'($signed(im1));
    assign cx     = PW'($signed(tw_re));
    assign dx     = PW'($signed(tw_im));
    assign mul_re = ax * cx - bx * dx;
    assign mul_im = ax * dx + bx * cx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_re  <= '0;
            p_im  <= '0;
            en2   <= 1'b0;
            zero2 <= 1'b0;
            re2   <= '0;
            im2   <= '0;
        end else begin
            p_re  <= mul_re;
            p_im  <= mul_im;
            en2   <= en1;
            zero2 <= zero1;
            re2   <= re1;
            im2   <= im1;
        end
    end

    // ---------------- stage 3: round, saturate or bypass; hold when idle
    function automatic logic [WIDTH-1:0] rnd_sat(input logic signed [PW-1:0] p);
        logic signed [PW1-1:0] s;
        logic [WIDTH-1:0]      r;
        s = (PW1'(p) + RND) >>> (WIDTH - 1);
        if (s > SAT_HI)      r = SAT_HI[WIDTH-1:0];
        else if (s < SAT_LO) r = SAT_LO[WIDTH-1:0];
        else                 r = s[WIDTH-1:0];
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            do_en <= 1'b0;
            do_re <= '0;
            do_im <= '0;
        end else begin
            do_en <= en2;
            if (en2) begin
                do_re <= zero2 ? re2 : rnd_sat(p_re);
                do_im <= zero2 ? im2 : rnd_sat(p_im);
            end
        end
    end

endmodule

// File: tb/tb_twiddle_mult.sv
// Bench for twiddle_mult: LOG_N=6 and LOG_N=4 instances against a trigonometric reference.
// Latency: expects each output 3 clocks after its input is presented.
// Backpressure: none exercised; the DUT has no stall path.
module tb_twiddle_mult;

    localparam real PI = 3.14159265358979323846;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        en6, en4;
    logic [15:0] re6, im6, re4, im4;
    logic        do_en6, do_en4;
    logic [15:0] do_re6, do_im6, do_re4, do_im4;

    always #5 clock = ~clock;

    twiddle_mult #(.LOG_N(6), .WIDTH(16)) dut6 (
        .clock (clock), .reset_n (reset_n),
        .di_en (en6), .di_re (re6), .di_im (im6),
        .do_en (do_en6), .do_re (do_re6), .do_im (do_im6)
    );

    twiddle_mult #(.LOG_N(4), .WIDTH(16)) dut4 (
        .clock (clock), .reset_n (reset_n),
        .di_en (en4), .di_re (re4), .di_im (im4),
        .do_en (do_en4), .do_re (do_re4), .do_im (do_im4)
    );

    typedef struct packed {
        logic        en;
        logic [15:0] re;
        logic [15:0] im;
    } out_t;

    int   checks   = 0;
    int   failures = 0;
    out_t q6[$];
    out_t q4[$];
    out_t last6, last4;
    int   m_cnt6, m_cnt4;
    int   addr4_tab [16] = '{0, 0, 0, 0, 0, 8, 16, 24, 0, 4, 8, 12, 0, 12, 24, 36};

    function automatic longint q15(input real x);
        real y;
        y = $floor(x * 32768.0 + 0.5);
        if (y > 32767.0)  y = 32767.0;
        if (y < -32768.0) y = -32768.0;
        return longint'($rtoi(y));
    endfunction

    function automatic longint rnd_clip(input longint p);
        longint r;
        r = (p + 64'sd16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference: multiply by exp(-j*2*pi*addr/64); address 0 passes data through.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input int addr);
        real    ang;
        longint c, d, av, bv, rr, ri;
        if (addr == 0) return {a, b};
        ang = 2.0 * PI * real'(addr) / 64.0;
        c   = q15($cos(ang));
        d   = q15(-$sin(ang));
        av  = longint'($signed(a));
        bv  = longint'($signed(b));
        rr  = rnd_clip(av * c - bv * d);
        ri  = rnd_clip(av * d + bv * c);
        return {rr[15:0], ri[15:0]};
    endfunction

    // 64-point address: (cnt mod 16) times the bit-reversed frame quarter.
    function automatic int addr6(input int cnt);
        int quarter;
        quarter = cnt / 16;
        return (cnt % 16) * ((quarter % 2) * 2 + quarter / 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e6, input logic [15:0] a6, input logic [15:0] b6,
                        input logic e4, input logic [15:0] a4, input logic [15:0] b4);
        out_t x;
        en6 = e6; re6 = a6; im6 = b6;
        en4 = e4; re4 = a4; im4 = b4;
        if (e6) begin
            x.en = 1'b1;
            {x.re, x.im} = model(a6, b6, addr6(m_cnt6));
            m_cnt6 = (m_cnt6 + 1) % 64;
            last6 = x;
        end else begin
            x = last6;
            x.en = 1'b0;
        end
        q6.push_back(x);
        if (e4) begin
            x.en = 1'b1;
            {x.re, x.im} = model(a4, b4, addr4_tab[m_cnt4 % 16]);
            m_cnt4 = (m_cnt4 + 1) % 64;
            last4 = x;
        end else begin
            x = last4;
            x.en = 1'b0;
        end
        q4.push_back(x);
        @(posedge clock);
        #1;
        x = q6.pop_front();
        chk("n64_do_en", 32'(do_en6), 32'(x.en));
        chk("n64_do_re", 32'(do_re6), 32'(x.re));
        chk("n64_do_im", 32'(do_im6), 32'(x.im));
        x = q4.pop_front();
        chk("n16_do_en", 32'(do_en4), 32'(x.en));
        chk("n16_do_re", 32'(do_re4), 32'(x.re));
        chk("n16_do_im", 32'(do_im4), 32'(x.im));
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rnd6();
        step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 16'h0, 16'h0);
    endtask

    // Reset with valid inputs driven throughout; outputs must clear at once.
    task automatic do_reset();
        en6 = 1'b1; re6 = 16'h7123; im6 = 16'h8456;
        en4 = 1'b1; re4 = 16'h1111; im4 = 16'h2222;
        reset_n = 1'b0;
        #2;
        chk("rst_n64_en", 32'(do_en6), 32'h0);
        chk("rst_n64_re", 32'(do_re6), 32'h0);
        chk("rst_n64_im", 32'(do_im6), 32'h0);
        chk("rst_n16_en", 32'(do_en4), 32'h0);
        chk("rst_n16_re", 32'(do_re4), 32'h0);
        chk("rst_n16_im", 32'(do_im4), 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_hold_n64_en", 32'(do_en6), 32'h0);
        chk("rst_hold_n16_en", 32'(do_en4), 32'h0);
        reset_n = 1'b1;
        q6.delete();
        q4.delete();
        last6  = '0;
        last4  = '0;
        m_cnt6 = 0;
        m_cnt4 = 0;
        for (int i = 0; i < 2; i++) begin
            q6.push_back('0);
            q4.push_back('0);
        end
    endtask

    initial begin
        en6 = 1'b0; re6 = '0; im6 = '0;
        en4 = 1'b0; re4 = '0; im4 = '0;
        reset_n = 1'b1;
        #1;
        do_reset();

        // Bypass: constant sample for a whole frame; cnt 0..15 use address 0.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 16'h1234, 16'h0567, 1'b0, 16'h0, 16'h0);
            if (i >= 2 && i < 18) begin
                chk("bypass_re", 32'(do_re6), 32'h1234);
                chk("bypass_im", 32'(do_im6), 32'h0567);
            end
        end

        // Multiply at cnt=17 (address 2), after the 63->0 wrap.
        for (int i = 0; i < 17; i++) rnd6();
        step(1'b1, 16'h4000, 16'h0000, 1'b0, 16'h0, 16'h0);
        idle();
        idle();
        chk("mult_re", 32'(do_re6), 32'h3EC5);
        chk("mult_im", 32'(do_im6), 32'hF384);

        // Saturation at cnt=24 (address 16, twiddle -j).
        for (int i = 0; i < 6; i++) rnd6();
        step(1'b1, 16'h8000, 16'h0000, 1'b0, 16'h0, 16'h0);
        idle();
        idle();
        chk("sat_re", 32'(do_re6), 32'h0000);
        chk("sat_im", 32'(do_im6), 32'h7FFF);

        // Alternating gaps over 128 valid samples.
        for (int i = 0; i < 256; i++)
            step(i % 2 == 0, 16'($urandom), 16'($urandom), 1'b0, 16'h0, 16'h0);

        // Irregular gaps.
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 2) != 0, 16'($urandom), 16'($urandom), 1'b0, 16'h0, 16'h0);

        // Mid-frame reset with samples in flight at cnt=30.
        for (int g = 0; g < 64 && m_cnt6 != 30; g++) rnd6();
        rnd6();
        rnd6();
        do_reset();
        idle();
        idle();
        idle();
        step(1'b1, 16'h2468, 16'h1357, 1'b0, 16'h0, 16'h0);
        idle();
        idle();
        chk("post_rst_re", 32'(do_re6), 32'h2468);
        chk("post_rst_im", 32'(do_im6), 32'h1357);

        // 16-point stage: two frames back to back, then one with gaps.
        for (int i = 0; i < 32; i++)
            step(1'b0, 16'h0, 16'h0, 1'b1, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 40; i++)
            step(1'b0, 16'h0, 16'h0, $urandom_range(0, 1) != 0, 16'($urandom), 16'($urandom));
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
